// File: rtl/score_keeper.sv
// Pong score keeper: classifies wall contacts as paddle hits or misses,
// tracks both scores and sequences serve, play and game-over phases.
module score_keeper #(
  parameter int unsigned LEFT_LIMIT   = 14,
  parameter int unsigned RIGHT_LIMIT  = 626,
  parameter int unsigned PAD_H        = 64,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [5:0] width,
  input  logic [8:0] lpad_y,
  input  logic [8:0] rpad_y,
  input  logic       start,
  output logic       ball_rst,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit_l,
  output logic       hit_r,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam int unsigned CW     = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [10:0] X_WRAP = 11'd640;
  localparam logic [10:0] L_LIM  = 11'(LEFT_LIMIT);
  localparam logic [10:0] R_LIM  = 11'(RIGHT_LIMIT);
  localparam logic [10:0] PAD_HX = 11'(PAD_H);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic          hit_l_q, hit_l_d, hit_r_q, hit_r_d;
  logic          winner_q, winner_d;
  logic          cl_q, cl_d, cr_q, cr_d;

  logic [10:0] bx, by, w, x_end, y_end, lpad_end, rpad_end;
  logic        left_c, right_c, ovl_l, ovl_r;
  logic        point_l, point_r;

  // x >= 640 means the ball underflowed past column 0, so it is a left contact.
  always_comb begin
    bx       = {1'b0, ball_x};
    by       = {2'b0, ball_y};
    w        = {5'b0, width};
    x_end    = bx + w;
    y_end    = by + w;
    lpad_end = {2'b0, lpad_y} + PAD_HX;
    rpad_end = {2'b0, rpad_y} + PAD_HX;
    left_c   = (bx < L_LIM) || (bx >= X_WRAP);
    right_c  = (x_end > R_LIM) && (bx < X_WRAP);
    ovl_l    = (y_end > {2'b0, lpad_y}) && (by < lpad_end);
    ovl_r    = (y_end > {2'b0, rpad_y}) && (by < rpad_end);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SERVE;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      hit_l_q   <= 1'b0;
      hit_r_q   <= 1'b0;
      winner_q  <= 1'b0;
      cl_q      <= 1'b0;
      cr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hit_l_q   <= hit_l_d;
      hit_r_q   <= hit_r_d;
      winner_q  <= winner_d;
      cl_q      <= cl_d;
      cr_q      <= cr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hit_l_d   = 1'b0;
    hit_r_d   = 1'b0;
    winner_d  = winner_q;
    cl_d      = cl_q;
    cr_d      = cr_q;
    point_l   = 1'b0;
    point_r   = 1'b0;

    case (state_q)
      SERVE: begin
        cl_d = 1'b0;
        cr_d = 1'b0;
        if (frame_tick) begin
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PLAY: begin
        // Left contact takes priority; a simultaneous right contact is ignored.
        if (frame_tick) begin
          if (left_c) begin
            if (!cl_q) begin
              cl_d = 1'b1;
              if (ovl_l) hit_l_d = 1'b1;
              else begin
                score_r_d = score_r_q + 4'd1;
                point_r   = 1'b1;
              end
            end
          end else begin
            cl_d = 1'b0;
            if (right_c) begin
              if (!cr_q) begin
                cr_d = 1'b1;
                if (ovl_r) hit_r_d = 1'b1;
                else begin
                  score_l_d = score_l_q + 4'd1;
                  point_l   = 1'b1;
                end
              end
            end else begin
              cr_d = 1'b0;
            end
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 1'b0;
          cnt_d     = '0;
          state_d   = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase

    if (point_l || point_r) begin
      cl_d  = 1'b0;
      cr_d  = 1'b0;
      cnt_d = '0;
      if ((point_l && score_l_d == WIN) || (point_r && score_r_d == WIN)) begin
        state_d  = GAME_OVER;
        winner_d = point_r;
      end else begin
        state_d = SERVE;
      end
    end
  end

  always_comb begin
    ball_rst  = (state_q != PLAY);
    game_over = (state_q == GAME_OVER);
    state     = state_q;
    score_l   = score_l_q;
    score_r   = score_r_q;
    hit_l     = hit_l_q;
    hit_r     = hit_r_q;
    winner    = winner_q;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the ball position generator and consumes its upper-left X/Y coordinates once per frame.
- Compares the ball against the left and right paddle rows and classifies each wall contact as a hit or a miss.
- Maintains both players' scores, runs the serve/point/game-over state machine, and drives the active-high ball reset that re-centres the ball after each point.

Parameters:
- LEFT_LIMIT, 14: ball_x below this value is left-wall contact.
- RIGHT_LIMIT, 626: ball_x+width above this value is right-wall contact.
- PAD_H, 64: paddle height in pixels.
- SERVE_FRAMES, 60: frame ticks ball_rst is held after a point.
- WIN_SCORE, 9: score that ends the game (4-bit max 15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle strobe, one per frame; all detection is evaluated only on this cycle
- ball_x  in  10  ball upper-left X
- ball_y  in  9  ball upper-left Y
- width  in  6  ball width/height, 0-63
- lpad_y  in  9  left paddle top Y
- rpad_y  in  9  right paddle top Y
- start  in  1  level; restarts the game from GAME_OVER
- ball_rst  out  1  active-high reset to the ball block
- score_l  out  4  left player score
- score_r  out  4  right player score
- hit_l  out  1  one-cycle pulse on a left paddle hit
- hit_r  out  1  one-cycle pulse on a right paddle hit
- game_over  out  1  high while in GAME_OVER
- winner  out  1  0 = left, 1 = right; valid while game_over is high
- state  out  2  0 = SERVE, 1 = PLAY, 2 = GAME_OVER (debug LEDs)

Behaviour:
- Reset (reset == 0 at a clk edge):
  - score_l = score_r = 0.
  - hit_l = hit_r = 0, game_over = 0, winner = 0.
  - state = SERVE, ball_rst = 1, serve counter = 0.
  - Contact latches cl and cr cleared.
  - Reset overrides every other input in the same cycle.
- Arithmetic:
  - All sums use 11-bit unsigned arithmetic; inputs are zero-extended.
  - Wrap handling: ball_x >= 640 counts as left contact (ball underflowed past 0). ball_y >= 480 counts as top, i.e. no paddle overlap unless the overlap terms are true.
- Left contact: ball_x < LEFT_LIMIT or ball_x >= 640. Right contact: ball_x+width > RIGHT_LIMIT and ball_x < 640.
- Overlap with a paddle: ball_y+width > pad_y and ball_y < pad_y+PAD_H. Both comparisons are strict.
- SERVE state:
  - ball_rst = 1.
  - On each frame_tick the counter increments.
  - When the counter reaches SERVE_FRAMES-1 on a tick: go to PLAY, clear the counter, ball_rst = 0 from the next cycle.
- PLAY state (evaluated on frame_tick only):
  - Left contact with cl == 0: set cl.
    - If overlapping the left paddle: pulse hit_l.
    - Otherwise: score_r += 1, go to SERVE.
  - Right contact with cr == 0: symmetric (hit_r, or score_l += 1).
  - Contact while the latch is set: no action; each contact episode produces exactly one event.
  - cl clears on the first tick without left contact; cr clears likewise.
  - Both contacts on one tick (width large): left is evaluated first; the right contact is ignored that tick.
  - Latches clear on entry to SERVE.
- Scoring:
  - Score registers and hit pulses update one cycle after the frame_tick cycle.
  - ball_rst rises on the same edge that increments a score.
  - If the new score equals WIN_SCORE, go to GAME_OVER instead of SERVE.
  - winner = side that scored.
- GAME_OVER state:
  - ball_rst = 1, game_over = 1, scores frozen, frame_tick ignored.
  - start sampled high: scores cleared, winner cleared, go to SERVE with counter = 0.
- start is ignored outside GAME_OVER.
- hit_l and hit_r are never high in the same cycle as a score change. Pulses last exactly one clk cycle.

Test Plan:
- Reset held low 3 cycles, then released -> state=SERVE, ball_rst=1, scores 0. After 60 frame_ticks -> state=PLAY, ball_rst=0.
- PLAY, width=10, lpad_y=200, ball_x=12, ball_y=230, one tick -> hit_l pulse for 1 cycle, scores unchanged. ball_x=9 on the next tick -> no second hit_l. ball_x=20, then ball_x=12 -> hit_l again.
- PLAY, width=10, rpad_y=100, ball_x=620, ball_y=300, tick -> score_l=1, ball_rst=1, state=SERVE. ball_y=163 with rpad_y=100 (edge, 163<164) -> hit_r. ball_y=164 -> miss.
- Wrapped ball_x=1022, lpad_y far away, tick -> score_r increments. Same ball_x on following ticks during SERVE -> no further change.
- score_r=8, left miss -> score_r=9, game_over=1, winner=1, state=2. Further ticks change nothing. start=1 -> scores 0, state=SERVE.
- reset low mid-PLAY with score_l=5 and cl set -> all outputs at reset values on the next cycle. The first contact after leaving SERVE is counted.
